// File: rtl/reg_bank_arbiter_if.sv
// reg_bank_arbiter_if
// Requester-side and bank-side signals of the register-bank write arbiter.
//   req    : per-requester write request
//   lock   : per-requester burst-lock request (qualified by req)
//   addr   : flattened addresses, requester i at [i*AW +: AW]
//   wdata  : flattened write data, requester i at [i*WIDTH +: WIDTH]
//   gnt    : one-hot-or-zero grant
//   reg_en : one-hot-or-zero enable to the bank registers
//   reg_d  : shared data bus to the bank registers
//   busy   : arbiter is inside a locked burst
//   err    : one-cycle pulse after an out-of-range write
// master = requester/bank side, slave = arbiter.
interface reg_bank_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int NREG  = 8,
    parameter int AW    = 3
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       lock;
    logic [NREQ*AW-1:0]    addr;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREG-1:0]       reg_en;
    logic [WIDTH-1:0]      reg_d;
    logic                  busy;
    logic                  err;

    modport master (
        output req, lock, addr, wdata,
        input  gnt, reg_en, reg_d, busy, err
    );

    modport slave (
        input  req, lock, addr, wdata,
        output gnt, reg_en, reg_d, busy, err
    );
endinterface

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter
// Round-robin write arbiter for a bank of NREG enable registers shared by
// NREQ requesters, with a locked-burst mode of up to MAX_BURST writes.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : reg_bank_arbiter_if slave (req/lock/addr/wdata in,
//         gnt/reg_en/reg_d combinational out, busy/err registered out)
module reg_bank_arbiter #(
    parameter int WIDTH     = 4,
    parameter int NREQ      = 4,
    parameter int NREG      = 8,
    parameter int AW        = 3,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    reg_bank_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner;
    logic [CW-1:0]   cnt;
    logic            busy_q;
    logic            err_q;

    logic [AW-1:0]    addr_a  [NREQ];
    logic [WIDTH-1:0] wdata_a [NREQ];
    logic             have;
    logic [IW-1:0]    sel;
    logic [IW-1:0]    sel_wrap;
    logic             oor;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_a[i]  = bus.addr[i*AW +: AW];
            wdata_a[i] = bus.wdata[i*WIDTH +: WIDTH];
        end
    end

    // Winner selection. In IDLE the loop runs from the farthest position
    // back toward ptr so the last hit is the first requester at or after ptr.
    always_comb begin : arb
        logic [IW-1:0] idx;
        have = 1'b0;
        sel  = ptr;
        idx  = '0;
        if (state == IDLE) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                idx = IW'((int'(ptr) + k) % NREQ);
                if (bus.req[idx]) begin
                    have = 1'b1;
                    sel  = idx;
                end
            end
        end else begin
            sel  = owner;
            have = bus.req[owner];
        end
        // Reset gates every combinational output, so no write can land.
        if (!rst) begin
            have = 1'b0;
        end
    end

    assign oor      = int'(addr_a[sel]) >= NREG;
    assign sel_wrap = IW'((int'(sel) + 1) % NREQ);

    assign bus.gnt    = have ? (NREQ'(1) << sel) : '0;
    assign bus.reg_en = (have && !oor) ? (NREG'(1) << addr_a[sel]) : '0;
    assign bus.reg_d  = have ? wdata_a[sel] : '0;
    assign bus.busy   = busy_q;
    assign bus.err    = err_q;

    // In LOCKED sel equals owner, so sel_wrap is owner+1 on release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ptr    <= '0;
            owner  <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            err_q <= have && oor;
            case (state)
                IDLE: begin
                    if (have) begin
                        if (bus.lock[sel] && MAX_BURST > 1) begin
                            state  <= LOCKED;
                            owner  <= sel;
                            cnt    <= CW'(1);
                            busy_q <= 1'b1;
                        end else begin
                            ptr <= sel_wrap;
                        end
                    end
                end
                LOCKED: begin
                    if (!have) begin
                        // Owner dropped req: dead cycle, then back to round-robin.
                        state  <= IDLE;
                        ptr    <= sel_wrap;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (!bus.lock[owner] || (int'(cnt) + 1 == MAX_BURST)) begin
                            state  <= IDLE;
                            ptr    <= sel_wrap;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter
// Scoreboard bench: the driver applies one cycle of stimulus, asks the
// reference model what the arbiter must present in that cycle and queues it;
// the monitor pops and compares on the falling edge. A small bank of
// registers fed by reg_en/reg_d is compared against the model's bank.
module tb_reg_bank_arbiter;
    localparam int WIDTH     = 4;
    localparam int NREQ      = 4;
    localparam int NREG      = 6;
    localparam int AW        = 3;
    localparam int MAX_BURST = 4;

    typedef struct packed {
        logic [NREQ-1:0]  gnt;
        logic [NREG-1:0]  en;
        logic [WIDTH-1:0] d;
        logic             busy;
        logic             err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_bank_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .NREG(NREG), .AW(AW)) bus_if ();

    reg_bank_arbiter #(
        .WIDTH(WIDTH), .NREQ(NREQ), .NREG(NREG), .AW(AW), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    // Requester-side stimulus state
    logic [NREQ-1:0] req_v  = '0;
    logic [NREQ-1:0] lock_v = '0;
    int addr_v [NREQ];
    int data_v [NREQ];

    // Reference model state
    int m_ptr, m_locked, m_owner, m_cnt, m_err;
    int m_bank [NREG];

    // Register bank driven by the arbiter outputs
    logic [WIDTH-1:0] tb_bank [NREG];
    logic bank_clr = 1'b1;
    always @(posedge clk) begin
        for (int r = 0; r < NREG; r++) begin
            if (bank_clr) tb_bank[r] <= '0;
            else if (bus_if.reg_en[r]) tb_bank[r] <= bus_if.reg_d;
        end
    end

    exp_t exp_q [$];
    exp_t mon_e;
    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("gnt",    int'(bus_if.gnt),    int'(mon_e.gnt));
            chk("reg_en", int'(bus_if.reg_en), int'(mon_e.en));
            chk("reg_d",  int'(bus_if.reg_d),  int'(mon_e.d));
            chk("busy",   int'(bus_if.busy),   int'(mon_e.busy));
            chk("err",    int'(bus_if.err),    int'(mon_e.err));
        end
    end

    // Who wins this cycle: the owner alone while locked, otherwise the first
    // requester found walking upward from the pointer.
    function automatic int pick();
        int i;
        if (m_locked != 0) return req_v[m_owner] ? m_owner : -1;
        for (int k = 0; k < NREQ; k++) begin
            i = (m_ptr + k) % NREQ;
            if (req_v[i]) return i;
        end
        return -1;
    endfunction

    task automatic item(input int i, input logic r, input logic l, input int a, input int d);
        req_v[i]  = r;
        lock_v[i] = l;
        addr_v[i] = a;
        data_v[i] = d;
    endtask

    // One clock cycle: drive, predict, queue the expectation, cross the edge.
    task automatic cycle(input logic rv, output int g);
        exp_t e;
        rst = rv;
        bus_if.req  = req_v;
        bus_if.lock = lock_v;
        for (int i = 0; i < NREQ; i++) begin
            bus_if.addr[i*AW +: AW]       = AW'(addr_v[i]);
            bus_if.wdata[i*WIDTH +: WIDTH] = WIDTH'(data_v[i]);
        end
        e = '0;
        g = -1;
        if (!rv) begin
            m_ptr = 0; m_locked = 0; m_owner = 0; m_cnt = 0; m_err = 0;
        end else begin
            g = pick();
            e.busy = (m_locked != 0);
            e.err  = (m_err != 0);
            m_err  = 0;
            if (g >= 0) begin
                e.gnt = NREQ'(1) << g;
                e.d   = WIDTH'(data_v[g]);
                if (addr_v[g] < NREG) begin
                    e.en = NREG'(1) << addr_v[g];
                    m_bank[addr_v[g]] = data_v[g];
                end else begin
                    m_err = 1;
                end
            end
            if (m_locked != 0) begin
                if (g < 0) begin
                    m_locked = 0;
                    m_ptr = (m_owner + 1) % NREQ;
                end else begin
                    m_cnt++;
                    if (!lock_v[m_owner] || m_cnt == MAX_BURST) begin
                        m_locked = 0;
                        m_ptr = (m_owner + 1) % NREQ;
                    end
                end
            end else if (g >= 0) begin
                if (lock_v[g] && MAX_BURST > 1) begin
                    m_locked = 1; m_owner = g; m_cnt = 1;
                end else begin
                    m_ptr = (g + 1) % NREQ;
                end
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int g;
        for (int i = 0; i < NREQ; i++) item(i, 1'b0, 1'b0, 0, 0);
        for (int r = 0; r < NREG; r++) m_bank[r] = 0;
        m_ptr = 0; m_locked = 0; m_owner = 0; m_cnt = 0; m_err = 0;
        @(posedge clk);
        #1;
        bank_clr = 1'b0;

        // Reset held with every requester asking
        for (int i = 0; i < NREQ; i++) item(i, 1'b1, 1'b0, i, 'hA + i);
        repeat (2) cycle(1'b0, g);

        // Round-robin 0,1,2,3,0
        repeat (5) cycle(1'b1, g);
        for (int i = 0; i < NREQ; i++) chk("rr_bank", int'(tb_bank[i]), 'hA + i);

        // Move the pointer to 2, then a locked burst by requester 2
        for (int i = 0; i < NREQ; i++) item(i, 1'b0, 1'b0, 0, 0);
        item(1, 1'b1, 1'b0, 4, 1);
        cycle(1'b1, g);
        item(0, 1'b1, 1'b0, 0, 2);
        item(1, 1'b1, 1'b0, 1, 3);
        item(2, 1'b1, 1'b1, 5, 4);
        item(3, 1'b1, 1'b0, 3, 5);
        for (int c = 0; c < 6; c++) begin
            cycle(1'b1, g);
            if (g >= 0) data_v[g] = (data_v[g] + 3) % 16;
        end

        // Requester 1 locks, transfers twice, then drops req
        item(2, 1'b0, 1'b0, 0, 0);
        item(1, 1'b1, 1'b1, 2, 5);
        cycle(1'b1, g);
        item(1, 1'b1, 1'b1, 2, 6);
        cycle(1'b1, g);
        item(1, 1'b0, 1'b0, 0, 0);
        repeat (2) cycle(1'b1, g);

        // Out-of-range writes (addresses 7 and 6)
        for (int i = 0; i < NREQ; i++) item(i, 1'b0, 1'b0, 0, 0);
        item(0, 1'b1, 1'b0, 7, 9);
        cycle(1'b1, g);
        item(0, 1'b0, 1'b0, 0, 0);
        repeat (2) cycle(1'b1, g);
        item(3, 1'b1, 1'b0, 6, 12);
        cycle(1'b1, g);
        item(3, 1'b0, 1'b0, 0, 0);
        cycle(1'b1, g);

        // Reset during the third locked transfer
        item(2, 1'b1, 1'b1, 1, 3);
        cycle(1'b1, g);
        item(2, 1'b1, 1'b1, 1, 4);
        cycle(1'b1, g);
        item(2, 1'b1, 1'b1, 1, 14);
        cycle(1'b0, g);
        chk("rst_burst_bank", int'(tb_bank[1]), 4);
        item(2, 1'b0, 1'b0, 0, 0);
        cycle(1'b1, g);
        item(1, 1'b1, 1'b0, 0, 6);
        item(3, 1'b1, 1'b0, 0, 7);
        cycle(1'b1, g);
        for (int i = 0; i < NREQ; i++) item(i, 1'b0, 1'b0, 0, 0);
        cycle(1'b1, g);

        // Randomized traffic obeying the requester hold/next-item rules
        for (int c = 0; c < 400; c++) begin
            cycle(1'b1, g);
            if (g >= 0) begin
                if ($urandom_range(3) != 0)
                    item(g, 1'b1, $urandom_range(9) < 4, int'($urandom_range(7)), int'($urandom_range(15)));
                else
                    item(g, 1'b0, 1'b0, 0, 0);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!req_v[i] && $urandom_range(9) < 4)
                    item(i, 1'b1, $urandom_range(9) < 4, int'($urandom_range(7)), int'($urandom_range(15)));
            end
        end

        for (int i = 0; i < NREQ; i++) item(i, 1'b0, 1'b0, 0, 0);
        repeat (2) cycle(1'b1, g);
        for (int r = 0; r < NREG; r++) chk("bank_final", int'(tb_bank[r]), m_bank[r]);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
